// File: rtl/cnt_poll_pkg.sv
// Shared types and constants for the counter polling read master.
package cnt_poll_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAr   = 2'd1,
    StR    = 2'd2,
    StOut  = 2'd3
  } state_e;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [11:0] CNT_ADDR_DEFAULT = 12'h000;

endpackage

// File: rtl/cnt_poll_timer.sv
// Free-running period timer; pulses start_o every period_i cycles while enabled.
module cnt_poll_timer #(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                start_o
);

  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [PERIOD_W-1:0] last_cnt;

  always_comb begin
    // A period of 0 behaves like 1: start on every enabled cycle.
    last_cnt = (period_i == '0) ? '0 : period_i - PERIOD_W'(1);
    // >= so that shrinking the period below the running count still fires.
    start_o  = enable_i && (timer_q >= last_cnt);
    timer_d  = timer_q;
    if (!enable_i || start_o) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/cnt_poll_master.sv
// AXI4-Lite read master that samples a 64-bit counter periodically or on trigger
// and streams timestamp plus delta to the previous good sample.
module cnt_poll_master
  import cnt_poll_pkg::*;
#(
  parameter logic [11:0] CNT_ADDR = CNT_ADDR_DEFAULT,
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned OVR_W    = 8
) (
  input  logic                m_axi_aclk,
  input  logic                m_axi_aresetn,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic                trigger,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  output logic [11:0]         m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  input  logic [1:0]          m_axi_rresp,
  input  logic [63:0]         m_axi_rdata,
  output logic                smp_valid,
  input  logic                smp_ready,
  output logic [63:0]         smp_ts,
  output logic [63:0]         smp_delta,
  output logic                smp_first,
  output logic                smp_restart,
  output logic                err_sticky,
  output logic [OVR_W-1:0]    ovr_cnt
);

  state_e             state_q, state_d;
  logic [63:0]        ts_q, ts_d;
  logic [63:0]        delta_q, delta_d;
  logic               first_q, first_d;
  logic               restart_q, restart_d;
  logic               have_prev_q, have_prev_d;
  logic               err_q, err_d;
  logic [OVR_W-1:0]   ovr_q, ovr_d;
  logic               per_start;
  logic               start;

  cnt_poll_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk_i    (m_axi_aclk),
    .rst_ni   (m_axi_aresetn),
    .enable_i (enable),
    .period_i (period),
    .start_o  (per_start)
  );

  // A trigger coinciding with a periodic start is a single request.
  assign start = trigger | per_start;

  always_comb begin
    state_d     = state_q;
    ts_d        = ts_q;
    delta_d     = delta_q;
    first_d     = first_q;
    restart_d   = restart_q;
    have_prev_d = have_prev_q;
    err_d       = err_q;
    ovr_d       = ovr_q;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StAr;
      end
      StAr: begin
        if (m_axi_arready) state_d = StR;
      end
      StR: begin
        if (m_axi_rvalid) begin
          if (m_axi_rresp == RESP_OKAY) begin
            // ts_q doubles as the previous-sample register.
            ts_d        = m_axi_rdata;
            have_prev_d = 1'b1;
            if (!have_prev_q || (m_axi_rdata < ts_q)) begin
              first_d   = 1'b1;
              restart_d = have_prev_q;
              delta_d   = '0;
            end else begin
              first_d   = 1'b0;
              restart_d = 1'b0;
              delta_d   = m_axi_rdata - ts_q;
            end
            state_d = StOut;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StOut: begin
        if (smp_ready) state_d = StIdle;
      end
    endcase

    if (start && (state_q != StIdle) && (ovr_q != '1)) begin
      ovr_d = ovr_q + OVR_W'(1);
    end
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q     <= StIdle;
      ts_q        <= '0;
      delta_q     <= '0;
      first_q     <= 1'b0;
      restart_q   <= 1'b0;
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
      ovr_q       <= '0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_d;
      delta_q     <= delta_d;
      first_q     <= first_d;
      restart_q   <= restart_d;
      have_prev_q <= have_prev_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
    end
  end

  assign m_axi_arvalid = (state_q == StAr);
  assign m_axi_araddr  = CNT_ADDR;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = (state_q == StR);
  assign smp_valid     = (state_q == StOut);
  assign smp_ts        = ts_q;
  assign smp_delta     = delta_q;
  assign smp_first     = first_q;
  assign smp_restart   = restart_q;
  assign err_sticky    = err_q;
  assign ovr_cnt       = ovr_q;

endmodule

// File: tb/tb_cnt_poll_master.sv
// Directed bench for cnt_poll_master with a configurable-latency AXI4-Lite slave model.
module tb_cnt_poll_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable, trigger, smp_ready;
  logic [15:0] period;
  logic        arvalid, arready, rvalid, rready;
  logic [11:0] araddr;
  logic [2:0]  arprot;
  logic [1:0]  rresp;
  logic [63:0] rdata;
  logic        smp_valid, smp_first, smp_restart, err_sticky;
  logic [63:0] smp_ts, smp_delta;
  logic [3:0]  ovr_cnt;

  always #5 clk = ~clk;

  cnt_poll_master #(
    .CNT_ADDR (12'h000),
    .PERIOD_W (16),
    .OVR_W    (4)
  ) dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (rst_n),
    .enable        (enable),
    .period        (period),
    .trigger       (trigger),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_araddr  (araddr),
    .m_axi_arprot  (arprot),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready),
    .m_axi_rresp   (rresp),
    .m_axi_rdata   (rdata),
    .smp_valid     (smp_valid),
    .smp_ready     (smp_ready),
    .smp_ts        (smp_ts),
    .smp_delta     (smp_delta),
    .smp_first     (smp_first),
    .smp_restart   (smp_restart),
    .err_sticky    (err_sticky),
    .ovr_cnt       (ovr_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: decisions made on the falling edge, handshakes land on the next rising edge.
  logic [63:0] rdata_cfg = '0;
  logic [1:0]  rresp_cfg = 2'b00;
  int ar_wait_cfg = 0, r_wait_cfg = 0;
  int ar_hs = 0, smp_hs = 0, vld_seen = 0, proto_bad = 0, addr_bad = 0;
  int grant_cyc [8];
  bit pend = 0, ar_waiting = 0;
  int wcnt = 0;

  always @(negedge clk) begin
    arready = 1'b0;
    rvalid  = 1'b0;
    rdata   = '0;
    rresp   = 2'b00;
    if (!rst_n) begin
      pend = 0; ar_waiting = 0; wcnt = 0;
    end else begin
      if (ar_waiting && !arvalid) proto_bad++;
      if (arvalid && pend) proto_bad++;
      if (arvalid && (araddr != 12'h000 || arprot != 3'b000)) addr_bad++;
      ar_waiting = 0;
      if (arvalid && !pend) begin
        if (wcnt >= ar_wait_cfg) begin
          arready = 1'b1;
          if (ar_hs < 8) grant_cyc[ar_hs] = cyc;
          ar_hs++;
          pend = 1; wcnt = 0;
        end else begin
          wcnt++; ar_waiting = 1;
        end
      end else if (pend && rready) begin
        if (wcnt >= r_wait_cfg) begin
          rvalid = 1'b1; rdata = rdata_cfg; rresp = rresp_cfg;
          pend = 0; wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      if (smp_valid && smp_ready) smp_hs++;
      if (smp_valid) vld_seen++;
    end
  end

  task automatic pulse_trigger();
    @(posedge clk); #1 trigger = 1'b1;
    @(posedge clk); #1 trigger = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!smp_valid && lat < 60);
    if (!smp_valid) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic txn(input logic [63:0] d, input string tag, output int lat);
    rdata_cfg = d;
    rresp_cfg = 2'b00;
    pulse_trigger();
    wait_valid(tag, lat);
  endtask

  task automatic accept();
    @(posedge clk); #1 smp_ready = 1'b1;
    @(posedge clk); #1 smp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, h0, s0, v0, k;
    enable = 1'b0; trigger = 1'b0; smp_ready = 1'b0; period = 16'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_arvalid", arvalid, 0);
    check_eq("rst_rready", rready, 0);
    check_eq("rst_valid", smp_valid, 0);
    check_eq("rst_err", err_sticky, 0);
    check_eq("rst_ovr", ovr_cnt, 0);
    check_eq("rst_ts", smp_ts, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Two triggered reads, zero-wait slave
    txn(64'd100, "t1", lat);
    check_eq("t1_lat", lat, 3);
    check_eq("t1_ts", smp_ts, 100);
    check_eq("t1_delta", smp_delta, 0);
    check_eq("t1_first", smp_first, 1);
    check_eq("t1_restart", smp_restart, 0);
    accept();
    @(negedge clk);
    check_eq("t1_idle", smp_valid, 0);

    txn(64'd250, "t2", lat);
    check_eq("t2_lat", lat, 3);
    check_eq("t2_ts", smp_ts, 250);
    check_eq("t2_delta", smp_delta, 150);
    check_eq("t2_first", smp_first, 0);
    accept();

    // Periodic polling, period 10
    rdata_cfg = 64'd300;
    h0 = ar_hs;
    @(posedge clk); #1 period = 16'd10; enable = 1'b1; smp_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1 enable = 1'b0;
    repeat (8) @(posedge clk);
    #1 smp_ready = 1'b0;
    check_eq("t3_grants_ge3", (ar_hs - h0) >= 3, 1);
    check_eq("t3_gap0", grant_cyc[h0+1] - grant_cyc[h0], 10);
    check_eq("t3_gap1", grant_cyc[h0+2] - grant_cyc[h0+1], 10);
    check_eq("t3_ovr", ovr_cnt, 0);
    check_eq("t3_ts", smp_ts, 300);

    // Slow slave: arready after 5 waits, rvalid after 7 waits
    ar_wait_cfg = 5; r_wait_cfg = 7;
    h0 = ar_hs; s0 = smp_hs;
    txn(64'd400, "t4", lat);
    check_eq("t4_lat", lat, 15);
    check_eq("t4_one_ar", ar_hs - h0, 1);
    check_eq("t4_proto", proto_bad, 0);
    check_eq("t4_addr", addr_bad, 0);
    check_eq("t4_ts", smp_ts, 400);
    check_eq("t4_delta", smp_delta, 100);
    accept();
    repeat (10) @(posedge clk);
    check_eq("t4_one_smp", smp_hs - s0, 1);
    ar_wait_cfg = 0; r_wait_cfg = 0;

    // Counter restart
    txn(64'd5000, "t5a", lat);
    check_eq("t5a_delta", smp_delta, 4600);
    accept();
    txn(64'd20, "t5b", lat);
    check_eq("t5b_ts", smp_ts, 20);
    check_eq("t5b_restart", smp_restart, 1);
    check_eq("t5b_first", smp_first, 1);
    check_eq("t5b_delta", smp_delta, 0);
    accept();
    txn(64'd30, "t5c", lat);
    check_eq("t5c_delta", smp_delta, 10);
    check_eq("t5c_first", smp_first, 0);
    check_eq("t5c_restart", smp_restart, 0);
    accept();

    // Slave error: no sample, prev kept
    v0 = vld_seen;
    rdata_cfg = 64'd999; rresp_cfg = 2'b10;
    pulse_trigger();
    repeat (10) @(negedge clk);
    check_eq("t6_err", err_sticky, 1);
    check_eq("t6_no_valid", vld_seen - v0, 0);
    check_eq("t6_ts_kept", smp_ts, 30);
    txn(64'd45, "t6b", lat);
    check_eq("t6b_delta", smp_delta, 15);
    check_eq("t6b_first", smp_first, 0);
    accept();

    // period=1 with backpressure: held sample, saturating overrun
    rdata_cfg = 64'd60;
    @(posedge clk); #1 period = 16'd1; enable = 1'b1;
    wait_valid("t7", lat);
    repeat (20) @(negedge clk);
    check_eq("t7_valid_held", smp_valid, 1);
    check_eq("t7_ts_held", smp_ts, 60);
    check_eq("t7_delta_held", smp_delta, 15);
    check_eq("t7_ovr_sat", ovr_cnt, 15);
    @(posedge clk); #1 enable = 1'b0;
    accept();

    // Async reset while waiting in R
    r_wait_cfg = 10; rdata_cfg = 64'd70;
    pulse_trigger();
    k = 0;
    while (!rready && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("t8_in_r", rready, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t8_rready", rready, 0);
    check_eq("t8_arvalid", arvalid, 0);
    check_eq("t8_valid", smp_valid, 0);
    check_eq("t8_err", err_sticky, 0);
    check_eq("t8_ovr", ovr_cnt, 0);
    check_eq("t8_ts", smp_ts, 0);
    check_eq("t8_delta", smp_delta, 0);
    check_eq("t8_first", smp_first, 0);
    check_eq("t8_restart", smp_restart, 0);
    r_wait_cfg = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
